// File: rtl/complete_arb.sv
// complete_arb: multi-channel writeback stage. Each functional-unit channel
// feeds its own FIFO; up to WB_WIDTH heads are granted per cycle round-robin
// and registered onto the register-file write ports.
// Optional build macro: COMPLETE_ARB_PERF_EN adds perf_wb_count/perf_stall_count.
module complete_arb #(
    parameter int unsigned NUM_FU     = 4,
    parameter int unsigned WB_WIDTH   = 2,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned XLEN       = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_FU-1:0]          fu_valid,
    output logic [NUM_FU-1:0]          fu_ready,
    input  logic [NUM_FU*5-1:0]        fu_dest_reg_idx,
    input  logic [NUM_FU*XLEN-1:0]     fu_alu_result,
    input  logic [NUM_FU*XLEN-1:0]     fu_NPC,
    input  logic [NUM_FU-1:0]          fu_take_branch,
    output logic [WB_WIDTH-1:0]        wb_regfile_en,
    output logic [WB_WIDTH*5-1:0]      wb_regfile_idx,
    output logic [WB_WIDTH*XLEN-1:0]   wb_regfile_data
`ifdef COMPLETE_ARB_PERF_EN
    ,
    output logic [31:0]                perf_wb_count,
    output logic [31:0]                perf_stall_count
`endif
);

    localparam int unsigned IDX_W = 5;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned RR_W  = $clog2(NUM_FU);
    localparam logic [IDX_W-1:0] ZERO_REG = '0;

    logic [IDX_W-1:0]  mem_idx_q  [NUM_FU][FIFO_DEPTH];
    logic [XLEN-1:0]   mem_data_q [NUM_FU][FIFO_DEPTH];
    logic [PTR_W-1:0]  head_q     [NUM_FU];
    logic [PTR_W-1:0]  tail_q     [NUM_FU];
    logic [CNT_W-1:0]  count_q    [NUM_FU];
    logic [RR_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic [NUM_FU-1:0] enq, deq;
    logic [IDX_W-1:0]  enq_idx  [NUM_FU];
    logic [XLEN-1:0]   enq_data [NUM_FU];

    logic [WB_WIDTH-1:0] grant_vld;
    logic [RR_W-1:0]     grant_ch [WB_WIDTH];
    int unsigned         scan_ch;
    int unsigned         n_grant;
    logic [RR_W-1:0]     ch_sel;

    logic [WB_WIDTH-1:0]      wb_en_d;
    logic [WB_WIDTH*5-1:0]    wb_idx_d;
    logic [WB_WIDTH*XLEN-1:0] wb_data_d;

    // Ready from registered count; data chosen at enqueue; zero-register packets dropped.
    always_comb begin
        enq = '0;
        fu_ready = '0;
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            fu_ready[i] = (count_q[i] != CNT_W'(FIFO_DEPTH));
            enq_idx[i]  = fu_dest_reg_idx[i*IDX_W +: IDX_W];
            enq_data[i] = fu_take_branch[i] ? fu_NPC[i*XLEN +: XLEN]
                                            : fu_alu_result[i*XLEN +: XLEN];
            enq[i] = fu_valid[i] && (count_q[i] != CNT_W'(FIFO_DEPTH))
                     && (fu_dest_reg_idx[i*IDX_W +: IDX_W] != ZERO_REG);
        end
    end

    // Round-robin scan from rr_ptr, granting the first WB_WIDTH non-empty channels.
    always_comb begin
        deq       = '0;
        grant_vld = '0;
        for (int unsigned p = 0; p < WB_WIDTH; p++) grant_ch[p] = '0;
        rr_ptr_d  = rr_ptr_q;
        scan_ch   = 0;
        n_grant   = 0;
        ch_sel    = '0;
        for (int unsigned k = 0; k < NUM_FU; k++) begin
            scan_ch = (32'(rr_ptr_q) + k) % NUM_FU;
            ch_sel  = RR_W'(scan_ch);
            if ((n_grant < WB_WIDTH) && (count_q[ch_sel] != '0)) begin
                deq[ch_sel] = 1'b1;
                for (int unsigned p = 0; p < WB_WIDTH; p++) begin
                    if (p == n_grant) begin
                        grant_vld[p] = 1'b1;
                        grant_ch[p]  = ch_sel;
                    end
                end
                n_grant  = n_grant + 1;
                rr_ptr_d = (scan_ch == NUM_FU - 1) ? '0 : ch_sel + RR_W'(1);
            end
        end
    end

    // Route granted head entries to their write ports; idle ports drive zero.
    always_comb begin
        wb_en_d   = '0;
        wb_idx_d  = '0;
        wb_data_d = '0;
        for (int unsigned p = 0; p < WB_WIDTH; p++) begin
            if (grant_vld[p]) begin
                wb_en_d[p] = 1'b1;
                wb_idx_d[p*IDX_W +: IDX_W] = mem_idx_q[grant_ch[p]][head_q[grant_ch[p]]];
                wb_data_d[p*XLEN +: XLEN]  = mem_data_q[grant_ch[p]][head_q[grant_ch[p]]];
            end
        end
    end

    // FIFO storage; entries need no reset since pointers and counts gate them.
    always_ff @(posedge clock) begin
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            if (reset && enq[i]) begin
                mem_idx_q[i][tail_q[i]]  <= enq_idx[i];
                mem_data_q[i][tail_q[i]] <= enq_data[i];
            end
        end
    end

    // FIFO pointers and occupancy per channel.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                head_q[i]  <= '0;
                tail_q[i]  <= '0;
                count_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                if (enq[i]) tail_q[i] <= tail_q[i] + PTR_W'(1);
                if (deq[i]) head_q[i] <= head_q[i] + PTR_W'(1);
                case ({enq[i], deq[i]})
                    2'b10:   count_q[i] <= count_q[i] + CNT_W'(1);
                    2'b01:   count_q[i] <= count_q[i] - CNT_W'(1);
                    default: count_q[i] <= count_q[i];
                endcase
            end
        end
    end

    // Round-robin pointer and registered writeback ports.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rr_ptr_q        <= '0;
            wb_regfile_en   <= '0;
            wb_regfile_idx  <= '0;
            wb_regfile_data <= '0;
        end else begin
            rr_ptr_q        <= rr_ptr_d;
            wb_regfile_en   <= wb_en_d;
            wb_regfile_idx  <= wb_idx_d;
            wb_regfile_data <= wb_data_d;
        end
    end

`ifdef COMPLETE_ARB_PERF_EN
    // Retired-write and backpressure-stall counters, wrapping at 2^32.
    always_ff @(posedge clock) begin
        if (!reset) begin
            perf_wb_count    <= '0;
            perf_stall_count <= '0;
        end else begin
            perf_wb_count <= perf_wb_count + 32'($countones(wb_regfile_en));
            if (|(fu_valid & ~fu_ready)) perf_stall_count <= perf_stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_complete_arb.sv
// Testbench for complete_arb: directed steps plus random traffic, checked
// against a queue-based reference model of the writeback stage.
module tb_complete_arb;

    localparam int NUM_FU = 4;
    localparam int WB     = 2;
    localparam int DEPTH  = 2;
    localparam int XLEN   = 32;

    logic                     clock;
    logic                     reset;
    logic [NUM_FU-1:0]        fu_valid;
    logic [NUM_FU-1:0]        fu_ready;
    logic [NUM_FU*5-1:0]      fu_dest_reg_idx;
    logic [NUM_FU*XLEN-1:0]   fu_alu_result;
    logic [NUM_FU*XLEN-1:0]   fu_NPC;
    logic [NUM_FU-1:0]        fu_take_branch;
    logic [WB-1:0]            wb_regfile_en;
    logic [WB*5-1:0]          wb_regfile_idx;
    logic [WB*XLEN-1:0]       wb_regfile_data;
`ifdef COMPLETE_ARB_PERF_EN
    logic [31:0]              perf_wb_count;
    logic [31:0]              perf_stall_count;
`endif

    complete_arb #(.NUM_FU(NUM_FU), .WB_WIDTH(WB), .FIFO_DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clock           (clock),
        .reset           (reset),
        .fu_valid        (fu_valid),
        .fu_ready        (fu_ready),
        .fu_dest_reg_idx (fu_dest_reg_idx),
        .fu_alu_result   (fu_alu_result),
        .fu_NPC          (fu_NPC),
        .fu_take_branch  (fu_take_branch),
        .wb_regfile_en   (wb_regfile_en),
        .wb_regfile_idx  (wb_regfile_idx),
        .wb_regfile_data (wb_regfile_data)
`ifdef COMPLETE_ARB_PERF_EN
        ,
        .perf_wb_count   (perf_wb_count),
        .perf_stall_count(perf_stall_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [4:0]      idx;
        logic [XLEN-1:0] data;
    } pkt_t;

    // Reference model state
    pkt_t              mq [NUM_FU][$];
    int                rr;
    logic [WB-1:0]     exp_en;
    logic [WB*5-1:0]   exp_idx;
    logic [WB*XLEN-1:0] exp_data;
    logic [NUM_FU-1:0] exp_rdy;
    logic [NUM_FU-1:0] acc;
    logic [31:0]       exp_wb_cnt;
    logic [31:0]       exp_stall_cnt;

    int vectors;
    int miscompares;
    int seq;
    logic seen_block;

    // Apply the specification's rules for one rising edge using current inputs.
    task automatic model_edge();
        logic [NUM_FU-1:0] rdy;
        int ng;
        int last;
        int ch;
        pkt_t p;
        for (int i = 0; i < NUM_FU; i++) rdy[i] = (mq[i].size() != DEPTH);
        acc = '0;
        if (!reset) begin
            for (int i = 0; i < NUM_FU; i++) mq[i].delete();
            rr = 0;
            exp_en = '0; exp_idx = '0; exp_data = '0;
            exp_wb_cnt = '0; exp_stall_cnt = '0;
        end else begin
            exp_wb_cnt = exp_wb_cnt + 32'($countones(exp_en));
            if (|(fu_valid & ~rdy)) exp_stall_cnt = exp_stall_cnt + 32'd1;
            exp_en = '0; exp_idx = '0; exp_data = '0;
            ng = 0;
            last = -1;
            for (int k = 0; k < NUM_FU; k++) begin
                ch = (rr + k) % NUM_FU;
                if (ng < WB && mq[ch].size() > 0) begin
                    p = mq[ch].pop_front();
                    exp_en[ng] = 1'b1;
                    exp_idx[ng*5 +: 5] = p.idx;
                    exp_data[ng*XLEN +: XLEN] = p.data;
                    ng++;
                    last = ch;
                end
            end
            for (int i = 0; i < NUM_FU; i++) begin
                if (fu_valid[i] && rdy[i]) begin
                    acc[i] = 1'b1;
                    if (fu_dest_reg_idx[i*5 +: 5] != 5'd0) begin
                        p.idx  = fu_dest_reg_idx[i*5 +: 5];
                        p.data = fu_take_branch[i] ? fu_NPC[i*XLEN +: XLEN]
                                                   : fu_alu_result[i*XLEN +: XLEN];
                        mq[i].push_back(p);
                    end
                end
            end
            if (last >= 0) rr = (last + 1) % NUM_FU;
        end
        for (int i = 0; i < NUM_FU; i++) exp_rdy[i] = (mq[i].size() != DEPTH);
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Advance one edge and compare DUT against the model.
    task automatic cycle();
        model_edge();
        @(posedge clock);
        #1;
        chk("wb_ports", {wb_regfile_en, wb_regfile_idx, wb_regfile_data},
                        {exp_en, exp_idx, exp_data});
        chk("fu_ready", fu_ready, exp_rdy);
`ifdef COMPLETE_ARB_PERF_EN
        chk("perf_wb_count", perf_wb_count, exp_wb_cnt);
        chk("perf_stall_count", perf_stall_count, exp_stall_cnt);
`endif
    endtask

    task automatic set_pkt(input int ch, input logic [4:0] d, input logic [XLEN-1:0] a,
                           input logic [XLEN-1:0] n, input logic t);
        fu_valid[ch]              = 1'b1;
        fu_dest_reg_idx[ch*5 +: 5] = d;
        fu_alu_result[ch*XLEN +: XLEN] = a;
        fu_NPC[ch*XLEN +: XLEN]   = n;
        fu_take_branch[ch]        = t;
    endtask

    // Present a fresh packet on each masked channel whose previous one was taken.
    task automatic refill(input logic [NUM_FU-1:0] mask);
        for (int i = 0; i < NUM_FU; i++) begin
            if (mask[i] && (!fu_valid[i] || acc[i])) begin
                set_pkt(i, 5'(i + 1), 32'(i * 256 + seq), 32'hDEAD0000 + 32'(seq), 1'b0);
                seq++;
            end
        end
    endtask

    // Random producers that hold a packet until it is accepted.
    task automatic rand_drive();
        for (int i = 0; i < NUM_FU; i++) begin
            if (!fu_valid[i] || acc[i]) begin
                if ($urandom_range(0, 99) < 60) begin
                    set_pkt(i, ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                            $urandom, $urandom, 1'($urandom_range(0, 1)));
                end else begin
                    fu_valid[i] = 1'b0;
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors = 0; miscompares = 0; seq = 0; seen_block = 1'b0;
        rr = 0; exp_en = '0; exp_idx = '0; exp_data = '0; exp_rdy = '1; acc = '0;
        exp_wb_cnt = '0; exp_stall_cnt = '0;
        reset = 1'b0;
        fu_valid = '0; fu_dest_reg_idx = '0; fu_alu_result = '0; fu_NPC = '0; fu_take_branch = '0;

        // Reset held two edges with every channel offering a packet
        for (int i = 0; i < NUM_FU; i++) set_pkt(i, 5'(i + 3), 32'h100 + 32'(i), 32'h200, 1'b0);
        repeat (2) begin
            cycle();
            chk("reset_en", wb_regfile_en, 2'b00);
            chk("reset_ready", fu_ready, 4'hF);
        end
        reset = 1'b1;
        fu_valid = '0;
        repeat (3) begin
            cycle();
            chk("post_reset_idle", wb_regfile_en, 2'b00);
        end

        // Single taken branch on channel 2: NPC written two edges later
        set_pkt(2, 5'd5, 32'h10, 32'h44, 1'b1);
        cycle();
        chk("branch_not_early", wb_regfile_en, 2'b00);
        fu_valid = '0;
        cycle();
        chk("branch_en", wb_regfile_en, 2'b01);
        chk("branch_idx", wb_regfile_idx[4:0], 5'd5);
        chk("branch_data", wb_regfile_data[31:0], 32'h44);
        cycle();
        chk("branch_done", wb_regfile_en, 2'b00);

        // Zero-register packets are swallowed
        set_pkt(0, 5'd0, 32'h1234, 32'h5678, 1'b0);
        repeat (3) begin
            cycle();
            chk("zero_ready0", fu_ready[0], 1'b1);
            chk("zero_no_write", wb_regfile_en, 2'b00);
        end
        fu_valid = '0;
        cycle();
        chk("zero_still_none", wb_regfile_en, 2'b00);

        // Round-robin with every channel kept non-empty, starting from rr=0
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        acc = '0;
        refill(4'hF);
        cycle();
        refill(4'hF);
        cycle();
        chk("rr_cycle1", wb_regfile_idx, {5'd2, 5'd1});
        refill(4'hF);
        cycle();
        chk("rr_cycle2", wb_regfile_idx, {5'd4, 5'd3});
        refill(4'hF);
        cycle();
        chk("rr_cycle3", wb_regfile_idx, {5'd2, 5'd1});

        // Channel 1 fed every cycle while all others stay busy
        repeat (14) begin
            refill(4'hF);
            cycle();
            if (!fu_ready[1]) seen_block = 1'b1;
        end
        chk("bp_ready_fell", seen_block, 1'b1);
        fu_valid = '0;
        repeat (6) cycle();

        // Reset in the middle of heavy traffic
        repeat (5) begin
            refill(4'hF);
            cycle();
        end
        reset = 1'b0;
        cycle();
        chk("midreset_en", wb_regfile_en, 2'b00);
        chk("midreset_ready", fu_ready, 4'hF);
        reset = 1'b1;
        fu_valid = '0;
        repeat (5) begin
            cycle();
            chk("midreset_no_stale", wb_regfile_en, 2'b00);
        end

        // Random traffic with occasional resets
        acc = '0;
        repeat (400) begin
            rand_drive();
            reset = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            cycle();
        end
        reset = 1'b1;
        fu_valid = '0;
        repeat (6) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
